// File: rtl/cp_insert_pp.sv
// -----------------------------------------------------------------------------
// cp_insert_pp
//
// Cyclic-prefix inserter with a ping-pong sample buffer. One time-domain
// symbol of runtime length fft_len is written into a bank. The block then
// emits the last cp_len samples of that bank (the prefix) followed by the whole
// symbol. While one bank is being read out, the other bank can be filled.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   cfg_fft_len_i    symbol length, legal 1..2^ADDR_W (sampled on first beat)
//   cfg_cp_len_i     prefix length, legal 0..fft_len (sampled on first beat)
//   s_data_i/s_valid_i/s_ready_o   input sample stream
//   m_data_o/m_valid_o/m_ready_i   output sample stream
//   m_cp_o           output sample belongs to the prefix
//   m_sof_o          first output sample of a symbol
//   m_last_o         last output sample of a symbol
//   cfg_err_o        sticky: an illegal configuration was latched and clamped
// -----------------------------------------------------------------------------
module cp_insert_pp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   cfg_fft_len_i,
    input  logic [ADDR_W:0]   cfg_cp_len_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_cp_o,
    output logic              m_sof_o,
    output logic              m_last_o,
    output logic              cfg_err_o
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CP,
        RD_BODY
    } rd_state_e;

    // ------------------------------------------------------------------
    // Configuration legalisation
    // ------------------------------------------------------------------
    logic            cfg_fft_bad;
    logic            cfg_cp_bad;
    logic [ADDR_W:0] cfg_fft_eff;
    logic [ADDR_W:0] cfg_cp_eff;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first or full if/else), otherwise a latch is inferred.
    always_comb begin
        cfg_fft_bad = (cfg_fft_len_i == '0) || (cfg_fft_len_i > MAX_LEN);
        cfg_fft_eff = cfg_fft_bad ? MAX_LEN : cfg_fft_len_i;
        cfg_cp_bad  = (cfg_cp_len_i > cfg_fft_eff);
        cfg_cp_eff  = cfg_cp_bad ? cfg_fft_eff : cfg_cp_len_i;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W:0]   bank_fft_q [2];
    logic [ADDR_W:0]   bank_cp_q  [2];
    logic [1:0]        full_q,   full_d;
    logic [1:0]        issued_q, issued_d;   // bank fully read from RAM, awaiting m_last
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W:0]   wr_cnt_q,  wr_cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              cfg_err_q;

    rd_state_e         rd_state_q, rd_state_d;
    logic              rd_bank_q,  rd_bank_d;
    logic [ADDR_W:0]   rd_addr_q,  rd_addr_d;
    logic              free_bank_q;          // bank whose m_last is next on the output

    logic [DATA_W-1:0] mem_q [2*DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              s1_v_q, s1_cp_q, s1_sof_q, s1_last_q;

    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q, m_cp_q, m_sof_q, m_last_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic            s_fire;
    logic            wr_first;
    logic [ADDR_W:0] wr_fft;
    logic            wr_end;

    always_comb begin
        s_fire   = s_valid_i && s_ready_q;
        wr_first = (wr_cnt_q == '0);
        // On the first beat the bank's length is not latched yet, so the
        // legalised input config decides whether this beat is also the last.
        wr_fft   = wr_first ? cfg_fft_eff : bank_fft_q[wr_bank_q];
        wr_end   = s_fire && (wr_cnt_q == wr_fft - ONE);
    end

    // ------------------------------------------------------------------
    // Read address generator. IDLE issues the first read of a symbol in the
    // same cycle it sees the bank ready, so symbols follow back to back.
    // ------------------------------------------------------------------
    logic            out_accept;
    logic            can_issue;
    logic            rd_issue;
    logic [ADDR_W:0] iss_addr;
    logic            iss_cp, iss_sof, iss_end, iss_last;
    logic [ADDR_W:0] cur_fft, cur_cp;

    always_comb begin
        out_accept = !m_valid_q || m_ready_i;
        can_issue  = !s1_v_q || out_accept;
        cur_fft    = bank_fft_q[rd_bank_q];
        cur_cp     = bank_cp_q[rd_bank_q];

        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_addr_d  = rd_addr_q;
        rd_issue   = 1'b0;
        iss_addr   = rd_addr_q;
        iss_cp     = 1'b0;
        iss_sof    = 1'b0;

        unique case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q] && !issued_q[rd_bank_q] && can_issue) begin
                    rd_issue = 1'b1;
                    iss_sof  = 1'b1;
                    iss_cp   = (cur_cp != '0);
                    iss_addr = iss_cp ? (cur_fft - cur_cp) : '0;
                end
            end
            RD_CP: begin
                rd_issue = can_issue;
                iss_cp   = 1'b1;
            end
            RD_BODY: begin
                rd_issue = can_issue;
            end
            default: rd_state_d = RD_IDLE;
        endcase

        iss_end  = (iss_addr == cur_fft - ONE);
        iss_last = rd_issue && !iss_cp && iss_end;

        if (rd_issue) begin
            if (iss_cp) begin
                rd_state_d = iss_end ? RD_BODY : RD_CP;
                rd_addr_d  = iss_end ? '0 : iss_addr + ONE;
            end else if (iss_end) begin
                rd_state_d = RD_IDLE;
                rd_bank_d  = ~rd_bank_q;
                rd_addr_d  = '0;
            end else begin
                rd_state_d = RD_BODY;
                rd_addr_d  = iss_addr + ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank flag bookkeeping. A freed bank and a newly filled bank are always
    // different banks, so both updates apply in the same cycle.
    // ------------------------------------------------------------------
    logic m_free;

    always_comb begin
        m_free   = m_valid_q && m_ready_i && m_last_q;
        full_d   = full_q;
        issued_d = issued_q;
        if (m_free) begin
            full_d[free_bank_q]   = 1'b0;
            issued_d[free_bank_q] = 1'b0;
        end
        if (wr_end) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (iss_last) begin
            issued_d[rd_bank_q] = 1'b1;
        end

        wr_bank_d = wr_end ? ~wr_bank_q : wr_bank_q;
        wr_cnt_d  = wr_end ? '0 : (s_fire ? wr_cnt_q + ONE : wr_cnt_q);
        s_ready_d = !full_d[wr_bank_d];
    end

    // ------------------------------------------------------------------
    // Sample RAM: synchronous write, synchronous read into rd_data_q.
    // ------------------------------------------------------------------
    // NOTE: the sample RAM and its read register have no reset; the full
    // flags guarantee nothing is read before it is written, and leaving the
    // array unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            mem_q[{wr_bank_q, wr_cnt_q[ADDR_W-1:0]}] <= s_data_i;
        end
        if (rd_issue) begin
            rd_data_q <= mem_q[{rd_bank_q, iss_addr[ADDR_W-1:0]}];
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_fft_q[0] <= '0;
            bank_fft_q[1] <= '0;
            bank_cp_q[0]  <= '0;
            bank_cp_q[1]  <= '0;
            full_q        <= '0;
            issued_q      <= '0;
            wr_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            s_ready_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
            rd_state_q    <= RD_IDLE;
            rd_bank_q     <= 1'b0;
            rd_addr_q     <= '0;
            free_bank_q   <= 1'b0;
            s1_v_q        <= 1'b0;
            s1_cp_q       <= 1'b0;
            s1_sof_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_cp_q        <= 1'b0;
            m_sof_q       <= 1'b0;
            m_last_q      <= 1'b0;
        end else begin
            if (s_fire && wr_first) begin
                bank_fft_q[wr_bank_q] <= cfg_fft_eff;
                bank_cp_q[wr_bank_q]  <= cfg_cp_eff;
                if (cfg_fft_bad || cfg_cp_bad) begin
                    cfg_err_q <= 1'b1;
                end
            end
            full_q     <= full_d;
            issued_q   <= issued_d;
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            s_ready_q  <= s_ready_d;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_addr_q  <= rd_addr_d;
            if (m_free) begin
                free_bank_q <= ~free_bank_q;
            end

            // Stage 1 holds the RAM read result; it only refills when its
            // content moves on, so rd_data_q is never overwritten early.
            if (can_issue) begin
                s1_v_q    <= rd_issue;
                s1_cp_q   <= iss_cp;
                s1_sof_q  <= iss_sof;
                s1_last_q <= iss_last;
            end

            // Output stage: holds steady while m_valid && !m_ready.
            if (out_accept) begin
                m_valid_q <= s1_v_q;
                m_cp_q    <= s1_v_q && s1_cp_q;
                m_sof_q   <= s1_v_q && s1_sof_q;
                m_last_q  <= s1_v_q && s1_last_q;
                if (s1_v_q) begin
                    m_data_q <= rd_data_q;
                end
            end
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_cp_o    = m_cp_q;
    assign m_sof_o   = m_sof_q;
    assign m_last_o  = m_last_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_cp_insert_pp.sv
// -----------------------------------------------------------------------------
// tb_cp_insert_pp
//
// Directed bench for cp_insert_pp. A behavioural model turns every complete
// input symbol into its expected output beat list (prefix then body); a
// monitor compares each output handshake against it and checks that outputs
// hold during stalls. Literal expectations pin latency, first samples, beat
// counts and the error flag.
// -----------------------------------------------------------------------------
module tb_cp_insert_pp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int MAXL   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W:0]   cfg_fft_len = '0;
    logic [ADDR_W:0]   cfg_cp_len  = '0;
    logic [DATA_W-1:0] s_data  = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_cp, m_sof, m_last, cfg_err;

    cp_insert_pp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_fft_len_i(cfg_fft_len),
        .cfg_cp_len_i (cfg_cp_len),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_cp_o       (m_cp),
        .m_sof_o      (m_sof),
        .m_last_o     (m_last),
        .cfg_err_o    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              cp;
        logic              sof;
        logic              last;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;

    bit                rdy_random = 1'b0;
    int                hs_count = 0;
    int                first_valid_cyc = -1;
    int                first_hs = -1;
    int                last_hs = -1;
    int                last_in_hs = -1;
    int                stall_cnt = 0;
    logic [DATA_W-1:0] first_data = '0;
    logic              first_cp = 1'b0;
    logic              first_sof = 1'b0;

    logic              prev_stall = 1'b0;
    logic              prev_valid = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [2:0]        prev_flags = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the output of a symbol is its last cp samples, then all samples.
    task automatic model_push(input int fft, input int cp, input int base);
        int    eff_fft;
        int    eff_cp;
        beat_t b;
        eff_fft = (fft == 0 || fft > MAXL) ? MAXL : fft;
        eff_cp  = (cp > eff_fft) ? eff_fft : cp;
        for (int k = 0; k < eff_cp; k++) begin
            b.data = DATA_W'(base + eff_fft - eff_cp + k);
            b.cp   = 1'b1;
            b.sof  = (k == 0);
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        for (int k = 0; k < eff_fft; k++) begin
            b.data = DATA_W'(base + k);
            b.cp   = 1'b0;
            b.sof  = (eff_cp == 0) && (k == 0);
            b.last = (k == eff_fft - 1);
            exp_q.push_back(b);
        end
    endtask

    // Sends nbeats samples base, base+1, ...; only a complete symbol feeds the
    // model. Config is scrambled after the first beat to prove it is latched.
    task automatic send_symbol(input int fft, input int cp, input int base, input int nbeats);
        int eff_fft;
        int guard;
        eff_fft = (fft == 0 || fft > MAXL) ? MAXL : fft;
        if (nbeats == eff_fft) model_push(fft, cp, base);
        cfg_fft_len = (ADDR_W + 1)'(fft);
        cfg_cp_len  = (ADDR_W + 1)'(cp);
        for (int i = 0; i < nbeats; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(base + i);
            guard   = 0;
            while (!s_ready && guard < 4000) begin
                @(negedge clk);
                guard++;
                stall_cnt++;
            end
            if (guard >= 4000) begin
                check("s_ready_timeout", s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            last_in_hs = cyc + 1;
            @(negedge clk);
            if (i == 0) begin
                cfg_fft_len = (ADDR_W + 1)'(3);
                cfg_cp_len  = (ADDR_W + 1)'(1);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic clr_track();
        hs_count        = 0;
        first_valid_cyc = -1;
        first_hs        = -1;
        last_hs         = -1;
        stall_cnt       = 0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check("idle_after_drain", m_valid, 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_flags", {m_cp, m_sof, m_last}, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);
    endtask

    // Monitor: drives m_ready, checks stall stability and each handshake.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                    check("hold_flags", {m_cp, m_sof, m_last}, prev_flags);
                end
                if (m_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                m_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_valid && m_ready) begin
                    check("out_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check("out_data", m_data, b.data);
                        check("out_cp", m_cp, b.cp);
                        check("out_sof", m_sof, b.sof);
                        check("out_last", m_last, b.last);
                    end
                    if (hs_count == 0) begin
                        first_data = m_data;
                        first_cp   = m_cp;
                        first_sof  = m_sof;
                        first_hs   = cyc + 1;
                    end
                    last_hs = cyc + 1;
                    hs_count++;
                end
                prev_stall = m_valid && !m_ready;
                prev_valid = m_valid;
                prev_data  = m_data;
                prev_flags = {m_cp, m_sof, m_last};
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Single symbol: 8 samples, 2-sample prefix.
        clr_track();
        send_symbol(8, 2, 0, 8);
        drain();
        check("t1_latency", first_valid_cyc, last_in_hs + 2);
        check("t1_first_data", first_data, 6);
        check("t1_first_sof_cp", {first_sof, first_cp}, 2'b11);
        check("t1_beats", hs_count, 10);
        check("t1_cfg_err", cfg_err, 0);

        // Three symbols back to back, data 0..23.
        clr_track();
        send_symbol(8, 2, 0, 8);
        send_symbol(8, 2, 8, 8);
        send_symbol(8, 2, 16, 8);
        drain();
        check("t2_beats", hs_count, 30);
        check("t2_gapless", last_hs - first_hs, 29);
        check("t2_input_stalled", stall_cnt != 0, 1);

        // Random backpressure on the output.
        clr_track();
        rdy_random = 1'b1;
        send_symbol(8, 2, 0, 8);
        drain();
        rdy_random = 1'b0;
        check("t3_beats", hs_count, 10);
        check("t3_first_data", first_data, 6);

        // No prefix.
        clr_track();
        send_symbol(4, 0, 10, 4);
        drain();
        check("t4_beats", hs_count, 4);
        check("t4_first_data", first_data, 10);
        check("t4_first_sof_cp", {first_sof, first_cp}, 2'b10);
        check("t4_cfg_err", cfg_err, 0);

        // Prefix longer than symbol is clamped; then fft_len=0 means 64.
        clr_track();
        send_symbol(4, 6, 32'hA, 4);
        drain();
        check("t5_beats", hs_count, 8);
        check("t5_first_data", first_data, 32'hA);
        check("t5_cfg_err", cfg_err, 1);
        clr_track();
        send_symbol(0, 0, 32'h100, 64);
        drain();
        check("t5_beats_64", hs_count, 64);
        check("t5_cfg_err_sticky", cfg_err, 1);

        // Reset in the middle of a symbol, then a fresh symbol.
        clr_track();
        send_symbol(8, 2, 200, 4);
        do_reset();
        clr_track();
        send_symbol(8, 1, 100, 8);
        drain();
        check("t6_beats", hs_count, 9);
        check("t6_first_data", first_data, 107);
        check("t6_first_sof_cp", {first_sof, first_cp}, 2'b11);
        check("t6_cfg_err", cfg_err, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
